// File: rtl/row_sequencer_if.sv
// Trace buffer read port: request/address out, acknowledge plus line entry back.
interface row_sequencer_if #(
    parameter int LINE_BITS = 9,
    parameter int STEP_FRAC = 12
);
    logic                   tb_req;
    logic [LINE_BITS-1:0]   tb_addr;
    logic                   tb_ack;
    logic [1:0]             tb_wall;
    logic                   tb_side;
    logic [10:0]            tb_size;
    logic [5:0]             tb_texu;
    logic [6+STEP_FRAC-1:0] tb_vstep;

    modport master (
        output tb_req, tb_addr,
        input  tb_ack, tb_wall, tb_side, tb_size, tb_texu, tb_vstep
    );

    modport slave (
        input  tb_req, tb_addr,
        output tb_ack, tb_wall, tb_side, tb_size, tb_texu, tb_vstep
    );
endinterface

// File: rtl/row_sequencer.sv
// Per-line wall controller: fetches a trace entry, computes the texv start
// offset with a shift-subtract multiply, then steps texv once per pixel.
module row_sequencer #(
    parameter int H_VIEW    = 640,
    parameter int STEP_FRAC = 12,
    parameter int LINE_BITS = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_line_start,
    input  logic [LINE_BITS-1:0] i_line_idx,
    input  logic                 i_pix_en,
    row_sequencer_if.master      tb,
    output logic [1:0]           o_wall,
    output logic                 o_side,
    output logic [10:0]          o_size,
    output logic [5:0]           o_texu,
    output logic [5:0]           o_texv,
    output logic                 o_ready,
    output logic                 o_late
);
    localparam int VW = 6 + STEP_FRAC;
    localparam logic [9:0] HALF_SIZE = 10'(H_VIEW / 2);
    localparam logic [VW-1:0] MID = {6'd32, {STEP_FRAC{1'b0}}};

    typedef enum logic [1:0] {IDLE, FETCH, MULT, READY} state_t;

    state_t               r_state;
    logic                 r_req;
    logic [LINE_BITS-1:0] r_addr;
    logic [1:0]           r_wall;
    logic                 r_side;
    logic [10:0]          r_size;
    logic [5:0]           r_texu;
    logic [VW-1:0]        r_vstep;
    logic [VW-1:0]        r_acc;
    logic [3:0]           r_cnt;
    logic                 r_ready;
    logic                 r_late;

    logic [VW-1:0]        w_sub;
    logic [VW-1:0]        w_mult;

    // MSB-first shift-subtract of HALF_SIZE*vstep; the last step adds 32.0
    always_comb begin
        w_sub  = HALF_SIZE[r_cnt] ? r_vstep : '0;
        w_mult = {r_acc[VW-2:0], 1'b0} - w_sub;
        if (r_cnt == 4'd0)
            w_mult = w_mult + MID;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_wall  <= '0;
            r_side  <= 1'b0;
            r_size  <= '0;
            r_texu  <= '0;
            r_vstep <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_late  <= 1'b0;
        end else begin
            r_late <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (i_line_start) begin
                        r_addr  <= i_line_idx;
                        r_req   <= 1'b1;
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    if (i_line_start) begin
                        r_addr <= i_line_idx;
                        r_req  <= 1'b0;
                        r_late <= 1'b1;
                    end else if (!r_req) begin
                        r_req <= 1'b1;
                    end else if (tb.tb_ack) begin
                        r_wall  <= tb.tb_wall;
                        r_side  <= tb.tb_side;
                        r_size  <= tb.tb_size;
                        r_texu  <= tb.tb_texu;
                        r_vstep <= tb.tb_vstep;
                        r_req   <= 1'b0;
                        r_acc   <= '0;
                        r_cnt   <= 4'd9;
                        r_state <= MULT;
                    end
                end
                MULT: begin
                    if (i_line_start) begin
                        r_addr  <= i_line_idx;
                        r_req   <= 1'b0;
                        r_late  <= 1'b1;
                        r_state <= FETCH;
                    end else begin
                        r_acc <= w_mult;
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt == 4'd0) begin
                            r_ready <= 1'b1;
                            r_state <= READY;
                        end
                    end
                end
                READY: begin
                    if (i_line_start) begin
                        r_addr  <= i_line_idx;
                        r_req   <= 1'b1;
                        r_ready <= 1'b0;
                        r_state <= FETCH;
                    end else if (i_pix_en) begin
                        r_acc <= r_acc + r_vstep;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tb.tb_req  = r_req;
    assign tb.tb_addr = r_addr;
    assign o_wall     = r_wall;
    assign o_side     = r_side;
    assign o_size     = r_size;
    assign o_texu     = r_texu;
    assign o_texv     = r_acc[VW-1:STEP_FRAC];
    assign o_ready    = r_ready;
    assign o_late     = r_late;
endmodule

// File: tb/tb_row_sequencer.sv
// Randomized bench for row_sequencer against an arithmetic texv model.
module tb_row_sequencer;
    localparam int H_VIEW = 640;
    localparam int SF     = 12;
    localparam int LB     = 9;
    localparam int VW     = 6 + SF;
    localparam int HALF   = H_VIEW / 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          line_start = 1'b0;
    logic [LB-1:0] line_idx = '0;
    logic          pix_en = 1'b0;
    logic [1:0]    o_wall;
    logic          o_side;
    logic [10:0]   o_size;
    logic [5:0]    o_texu;
    logic [5:0]    o_texv;
    logic          o_ready;
    logic          o_late;

    row_sequencer_if #(.LINE_BITS(LB), .STEP_FRAC(SF)) tbus ();

    row_sequencer #(
        .H_VIEW(H_VIEW), .STEP_FRAC(SF), .LINE_BITS(LB)
    ) dut (
        .clk(clk), .reset(reset),
        .i_line_start(line_start), .i_line_idx(line_idx),
        .i_pix_en(pix_en), .tb(tbus.master),
        .o_wall(o_wall), .o_side(o_side), .o_size(o_size),
        .o_texu(o_texu), .o_texv(o_texv),
        .o_ready(o_ready), .o_late(o_late)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int late_seen = 0;
    int cur_vs = 0;
    int pix_n = 0;

    always @(negedge clk) if (o_late === 1'b1) late_seen++;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // texv after n pixels: 32.0 - HALF*vstep + n*vstep, wrapped to 64.0
    function automatic int model_texv(input int vs, input int n);
        longint m;
        longint a;
        m = longint'(1) << VW;
        a = (longint'(32) << SF) - longint'(HALF) * vs + longint'(n) * vs;
        a = ((a % m) + m) % m;
        return int'(a >> SF);
    endfunction

    task automatic garbage();
        tbus.tb_wall  = 2'($urandom);
        tbus.tb_side  = 1'($urandom);
        tbus.tb_size  = 11'($urandom);
        tbus.tb_texu  = 6'($urandom);
        tbus.tb_vstep = VW'($urandom);
    endtask

    task automatic ack_and_wait(input logic [1:0] w, input logic s,
                                input logic [10:0] sz, input logic [5:0] tu,
                                input logic [VW-1:0] vs);
        int k;
        tbus.tb_wall  = w;
        tbus.tb_side  = s;
        tbus.tb_size  = sz;
        tbus.tb_texu  = tu;
        tbus.tb_vstep = vs;
        tbus.tb_ack   = 1'b1;
        step();
        tbus.tb_ack = 1'b0;
        garbage();
        check("req_drop", tbus.tb_req, 0);
        check("ready_mult", o_ready, 0);
        k = 1;
        while (!o_ready && k < 40) begin
            step();
            k++;
        end
        check("ready_lat", k, 11);
        check("wall", o_wall, w);
        check("side", o_side, s);
        check("size", o_size, sz);
        check("texu", o_texu, tu);
        cur_vs = int'(vs);
        pix_n = 0;
        check("texv_h0", o_texv, model_texv(cur_vs, 0));
    endtask

    task automatic start_line(input int idx, input int dly);
        line_start = 1'b1;
        line_idx = LB'(idx);
        step();
        line_start = 1'b0;
        check("req_rise", tbus.tb_req, 1);
        check("addr", tbus.tb_addr, idx);
        check("ready_fetch", o_ready, 0);
        repeat (dly) step();
    endtask

    task automatic run_pix(input int cycles, input int prob);
        for (int i = 0; i < cycles; i++) begin
            pix_en = ($urandom_range(0, 99) < prob);
            step();
            if (pix_en) pix_n++;
            check("texv_run", o_texv, model_texv(cur_vs, pix_n));
        end
        pix_en = 1'b0;
    endtask

    initial begin
        tbus.tb_ack = 1'b0;
        garbage();
        repeat (3) step();
        reset = 1'b0;
        check("rst_req", tbus.tb_req, 0);
        check("rst_addr", tbus.tb_addr, 0);
        check("rst_ready", o_ready, 0);
        check("rst_texv", o_texv, 0);
        check("rst_wall", o_wall, 0);
        repeat (20) step();
        check("idle_req", tbus.tb_req, 0);
        check("idle_ready", o_ready, 0);
        check("idle_late", late_seen, 0);

        start_line(5, 3);
        ack_and_wait(2'd2, 1'b1, 11'd256, 6'd17, VW'(512));
        check("texv_56", o_texv, 56);
        run_pix(64, 100);
        check("texv_64pix", o_texv, 0);
        run_pix(256, 100);
        check("texv_320pix", o_texv, 32);
        tbus.tb_wall = 2'd1;
        tbus.tb_texu = 6'd3;
        tbus.tb_ack = 1'b1;
        step();
        tbus.tb_ack = 1'b0;
        step();
        check("ack_rdy_wall", o_wall, 2);
        check("ack_rdy_texu", o_texu, 17);
        check("ack_rdy_ready", o_ready, 1);
        check("ack_rdy_texv", o_texv, 32);

        start_line(9, 0);
        ack_and_wait(2'd0, 1'b0, 11'd32, 6'd5, VW'(4096));
        check("texv_32", o_texv, 32);
        run_pix(31, 100);
        check("texv_63", o_texv, 63);
        run_pix(1, 100);
        check("texv_wrap", o_texv, 0);
        run_pix(5, 0);
        check("texv_hold", o_texv, 0);

        // abort four cycles into MULT, with a stale ack in the gap cycle
        start_line(3, 1);
        tbus.tb_wall = 2'd3;
        tbus.tb_ack = 1'b1;
        step();
        tbus.tb_ack = 1'b0;
        repeat (3) step();
        line_start = 1'b1;
        line_idx = LB'(7);
        step();
        line_start = 1'b0;
        check("late_pulse", o_late, 1);
        check("late_req_low", tbus.tb_req, 0);
        check("late_ready", o_ready, 0);
        tbus.tb_ack = 1'b1;
        step();
        tbus.tb_ack = 1'b0;
        check("late_once", o_late, 0);
        check("late_req_hi", tbus.tb_req, 1);
        check("late_addr", tbus.tb_addr, 7);
        step();
        ack_and_wait(2'd1, 1'b1, 11'd100, 6'd42, VW'(1234));
        run_pix(40, 80);

        // ack coinciding with line_start is discarded
        start_line(11, 0);
        line_start = 1'b1;
        line_idx = LB'(12);
        tbus.tb_wall = 2'd0;
        tbus.tb_texu = 6'd9;
        tbus.tb_ack = 1'b1;
        step();
        line_start = 1'b0;
        tbus.tb_ack = 1'b0;
        check("coin_late", o_late, 1);
        check("coin_req", tbus.tb_req, 0);
        check("coin_wall", o_wall, 1);
        check("coin_texu", o_texu, 42);
        step();
        check("coin_req_hi", tbus.tb_req, 1);
        check("coin_addr", tbus.tb_addr, 12);
        ack_and_wait(2'd2, 1'b0, 11'd500, 6'd60, VW'(77));
        run_pix(30, 60);

        // reset during FETCH
        start_line(20, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mrst_req", tbus.tb_req, 0);
        check("mrst_ready", o_ready, 0);
        check("mrst_texv", o_texv, 0);
        check("mrst_wall", o_wall, 0);
        check("mrst_late", o_late, 0);
        tbus.tb_wall = 2'd3;
        tbus.tb_ack = 1'b1;
        step();
        tbus.tb_ack = 1'b0;
        step();
        check("idle_ack_wall", o_wall, 0);
        check("idle_ack_req", tbus.tb_req, 0);
        start_line(21, 2);
        ack_and_wait(2'd3, 1'b1, 11'd64, 6'd1, VW'(2048));
        run_pix(20, 100);

        for (int it = 0; it < 6; it++) begin
            start_line($urandom_range(0, 511), $urandom_range(0, 4));
            ack_and_wait(2'($urandom), 1'($urandom), 11'($urandom),
                         6'($urandom), VW'($urandom));
            run_pix($urandom_range(50, 200), 70);
        end

        step();
        check("late_count", late_seen, 2);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
